// File: rtl/alu_issue_ctrl_pkg.sv
// Shared control encodings for the ALU issue front end: opcodes, ALU classes
// and the funct3 values the decoder recognises.
package ControlSignals;

    typedef enum logic [2:0] {
        OP_SUB = 3'b000,
        OP_AND = 3'b001,
        OP_OR  = 3'b011,
        OP_ADD = 3'b111
    } aluOperation_t;

    typedef enum logic [1:0] {
        CLASS_MEM    = 2'b00,
        CLASS_BRANCH = 2'b01,
        CLASS_RTYPE  = 2'b10,
        CLASS_RSVD   = 2'b11
    } aluClass_t;

    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_AND    = 3'b111;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_BEQ    = 3'b000;
    localparam logic [2:0] F3_BNE    = 3'b001;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request, ALU and response signals of alu_issue_ctrl. The slave modport is the
// issue controller's view; master is the view of its surroundings.
interface alu_issue_ctrl_if #(parameter int DATA_WIDTH_POW = 6);
    import ControlSignals::*;

    localparam int W = 1 << DATA_WIDTH_POW;

    logic          reqValid_in;
    logic          reqReady_out;
    logic [1:0]    aluClass_in;
    logic [2:0]    funct3_in;
    logic          funct7b5_in;
    logic [W-1:0]  operand1_in;
    logic [W-1:0]  operand2_in;
    aluOperation_t aluOp_out;
    logic [W-1:0]  aluOperand1_out;
    logic [W-1:0]  aluOperand2_out;
    logic [W-1:0]  aluResult_in;
    logic          aluZero_in;
    logic          respValid_out;
    logic          respReady_in;
    logic [W-1:0]  result_out;
    logic          zeroFlag_out;
    logic          branchTaken_out;
    logic          illegal_out;

    modport slave (
        input  reqValid_in, aluClass_in, funct3_in, funct7b5_in, operand1_in, operand2_in,
        input  aluResult_in, aluZero_in, respReady_in,
        output reqReady_out, aluOp_out, aluOperand1_out, aluOperand2_out,
        output respValid_out, result_out, zeroFlag_out, branchTaken_out, illegal_out
    );

    modport master (
        output reqValid_in, aluClass_in, funct3_in, funct7b5_in, operand1_in, operand2_in,
        output aluResult_in, aluZero_in, respReady_in,
        input  reqReady_out, aluOp_out, aluOperand1_out, aluOperand2_out,
        input  respValid_out, result_out, zeroFlag_out, branchTaken_out, illegal_out
    );

endinterface

// File: rtl/alu_issue_ctrl_op_decode.sv
// Maps ALU class / funct3 / funct7b5 to an ALU opcode and an illegal flag.
// With ALU_ISSUE_BRANCH_EN defined, branch funct3 values other than BEQ/BNE are illegal.
module alu_op_decode
    import ControlSignals::*;
(
    input  logic [1:0]    i_class,
    input  logic [2:0]    i_funct3,
    input  logic          i_funct7b5,
    output aluOperation_t o_op,
    output logic          o_illegal
);

    // NOTE: every output gets a default before the case, so no path can infer a latch.
    always_comb begin
        o_op      = OP_ADD;
        o_illegal = 1'b0;
        case (aluClass_t'(i_class))
            CLASS_MEM: o_op = OP_ADD;
            CLASS_BRANCH: begin
                o_op = OP_SUB;
`ifdef ALU_ISSUE_BRANCH_EN
                if (i_funct3 != F3_BEQ && i_funct3 != F3_BNE) begin
                    o_illegal = 1'b1;
                end
`endif
            end
            CLASS_RTYPE: begin
                case (i_funct3)
                    F3_ADDSUB: o_op = i_funct7b5 ? OP_SUB : OP_ADD;
                    F3_AND:    o_op = OP_AND;
                    F3_OR:     o_op = OP_OR;
                    default:   o_illegal = 1'b1;
                endcase
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Two-stage issue/response front end for an external combinational ALU.
// Define ALU_ISSUE_BRANCH_EN to compile in BEQ/BNE branch resolution.
module alu_issue_ctrl
    import ControlSignals::*;
#(
    parameter int DATA_WIDTH_POW = 6
) (
    input  logic           clk_in,
    input  logic           rstN_in,
    alu_issue_ctrl_if.slave bus
);

    localparam int W = 1 << DATA_WIDTH_POW;

    logic          r_s0_valid;
    aluOperation_t r_alu_op;
    logic [W-1:0]  r_op1;
    logic [W-1:0]  r_op2;
    logic          r_s0_illegal;

    logic          r_s1_valid;
    logic [W-1:0]  r_result;
    logic          r_zero;
    logic          r_s1_illegal;

    aluOperation_t w_dec_op;
    logic          w_dec_illegal;
    logic          w_s1_load;
    logic          w_req_ready;
    logic          w_accept;

    alu_op_decode u_decode (
        .i_class    (bus.aluClass_in),
        .i_funct3   (bus.funct3_in),
        .i_funct7b5 (bus.funct7b5_in),
        .o_op       (w_dec_op),
        .o_illegal  (w_dec_illegal)
    );

    // S0 advances exactly when S1 takes its contents, which keeps full throughput.
    assign w_s1_load   = r_s0_valid && (!r_s1_valid || bus.respReady_in);
    assign w_req_ready = !r_s0_valid || w_s1_load;
    assign w_accept    = bus.reqValid_in && w_req_ready;

`ifdef ALU_ISSUE_BRANCH_EN
    logic [1:0] r_s0_class;
    logic [2:0] r_s0_funct3;
    logic       r_s1_taken;
    logic       w_taken;

    always_comb begin
        w_taken = 1'b0;
        if (r_s0_class == CLASS_BRANCH && !r_s0_illegal) begin
            if (r_s0_funct3 == F3_BEQ) begin
                w_taken = bus.aluZero_in;
            end else if (r_s0_funct3 == F3_BNE) begin
                w_taken = !bus.aluZero_in;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rstN_in) begin
        if (!rstN_in) begin
            r_s0_class  <= '0;
            r_s0_funct3 <= '0;
            r_s1_taken  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_s0_class  <= bus.aluClass_in;
                r_s0_funct3 <= bus.funct3_in;
            end
            if (w_s1_load) begin
                r_s1_taken <= w_taken;
            end
        end
    end

    assign bus.branchTaken_out = r_s1_taken;
`else
    assign bus.branchTaken_out = 1'b0;
`endif

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in or negedge rstN_in) begin
        if (!rstN_in) begin
            r_s0_valid   <= 1'b0;
            r_alu_op     <= OP_ADD;
            r_op1        <= '0;
            r_op2        <= '0;
            r_s0_illegal <= 1'b0;
        end else if (w_accept) begin
            r_s0_valid   <= 1'b1;
            r_alu_op     <= w_dec_op;
            r_op1        <= bus.operand1_in;
            r_op2        <= bus.operand2_in;
            r_s0_illegal <= w_dec_illegal;
        end else if (w_s1_load) begin
            r_s0_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rstN_in) begin
        if (!rstN_in) begin
            r_s1_valid   <= 1'b0;
            r_result     <= '0;
            r_zero       <= 1'b0;
            r_s1_illegal <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid   <= 1'b1;
            r_result     <= bus.aluResult_in;
            r_zero       <= bus.aluZero_in;
            r_s1_illegal <= r_s0_illegal;
        end else if (bus.respReady_in) begin
            r_s1_valid   <= 1'b0;
        end
    end

    assign bus.reqReady_out    = w_req_ready;
    assign bus.aluOp_out       = r_alu_op;
    assign bus.aluOperand1_out = r_op1;
    assign bus.aluOperand2_out = r_op2;
    assign bus.respValid_out   = r_s1_valid;
    assign bus.result_out      = r_result;
    assign bus.zeroFlag_out    = r_zero;
    assign bus.illegal_out     = r_s1_illegal;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed vector table, backpressure and
// reset sequences, then randomized traffic against a behavioural scoreboard.
module tb_alu_issue_ctrl;
    import ControlSignals::*;

    localparam int DWP = 6;
    localparam int W   = 1 << DWP;
`ifdef ALU_ISSUE_BRANCH_EN
    localparam bit BR_EN = 1'b1;
`else
    localparam bit BR_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;

    alu_issue_ctrl_if #(.DATA_WIDTH_POW(DWP)) bus ();

    alu_issue_ctrl #(.DATA_WIDTH_POW(DWP)) dut (
        .clk_in  (clk),
        .rstN_in (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External combinational ALU.
    always_comb begin
        bus.aluResult_in = '0;
        case (bus.aluOp_out)
            OP_ADD:  bus.aluResult_in = bus.aluOperand1_out + bus.aluOperand2_out;
            OP_SUB:  bus.aluResult_in = bus.aluOperand1_out - bus.aluOperand2_out;
            OP_AND:  bus.aluResult_in = bus.aluOperand1_out & bus.aluOperand2_out;
            OP_OR:   bus.aluResult_in = bus.aluOperand1_out | bus.aluOperand2_out;
            default: bus.aluResult_in = '0;
        endcase
        bus.aluZero_in = (bus.aluResult_in == '0);
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [W-1:0] result;
        logic         zero;
        logic         taken;
        logic         illegal;
    } resp_t;

    // Reference: what the instruction means, computed directly from the class rules.
    function automatic resp_t model(input logic [1:0] cls, input logic [2:0] f3,
                                    input logic f7, input logic [W-1:0] a,
                                    input logic [W-1:0] b);
        resp_t r;
        r.illegal = 1'b0;
        r.taken   = 1'b0;
        if (cls == 2'd0) begin
            r.result = a + b;
        end else if (cls == 2'd1) begin
            r.result  = a - b;
            r.illegal = BR_EN && (f3 != 3'd0) && (f3 != 3'd1);
        end else if (cls == 2'd2 && f3 == 3'd0) begin
            r.result = f7 ? (a - b) : (a + b);
        end else if (cls == 2'd2 && f3 == 3'd7) begin
            r.result = a & b;
        end else if (cls == 2'd2 && f3 == 3'd6) begin
            r.result = a | b;
        end else begin
            r.result  = a + b;
            r.illegal = 1'b1;
        end
        r.zero = (r.result == '0);
        if (BR_EN && cls == 2'd1 && f3 == 3'd0) r.taken = (a == b);
        if (BR_EN && cls == 2'd1 && f3 == 3'd1) r.taken = (a != b);
        return r;
    endfunction

    typedef struct {
        logic [1:0]   cls;
        logic [2:0]   f3;
        logic         f7;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_res;
        logic         exp_zero;
        logic         exp_taken;
        logic         exp_illegal;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs[NV];
    resp_t exp_q[$];

    task automatic drive_req(input logic v, input logic [1:0] cls, input logic [2:0] f3,
                             input logic f7, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.reqValid_in = v;
        bus.aluClass_in = cls;
        bus.funct3_in   = f3;
        bus.funct7b5_in = f7;
        bus.operand1_in = a;
        bus.operand2_in = b;
    endtask

    task automatic check_resp(input string tag, input resp_t e);
        check({tag, " result"},  bus.result_out, e.result);
        check({tag, " zero"},    W'(bus.zeroFlag_out), W'(e.zero));
        check({tag, " taken"},   W'(bus.branchTaken_out), W'(e.taken));
        check({tag, " illegal"}, W'(bus.illegal_out), W'(e.illegal));
    endtask

    function automatic resp_t vec_resp(input vec_t v);
        resp_t r;
        r.result  = v.exp_res;
        r.zero    = v.exp_zero;
        r.taken   = v.exp_taken;
        r.illegal = v.exp_illegal;
        return r;
    endfunction

    initial begin
        int accepts, idx, got, first_cyc, last_cyc, seen;
        logic prev_stall;
        logic [W-1:0] prev_res;
        resp_t e;

        vecs[0]  = '{2'b10, 3'b000, 1'b1, 64'd10, 64'd3, 64'd7, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{2'b01, 3'b000, 1'b0, 64'd5, 64'd5, 64'd0, 1'b1, BR_EN, 1'b0};
        vecs[2]  = '{2'b01, 3'b001, 1'b0, 64'd5, 64'd5, 64'd0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{2'b01, 3'b001, 1'b0, 64'd9, 64'd4, 64'd5, 1'b0, BR_EN, 1'b0};
        vecs[4]  = '{2'b10, 3'b010, 1'b0, 64'd4, 64'd6, 64'd10, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{2'b11, 3'b000, 1'b0, 64'd7, 64'd8, 64'd15, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{2'b10, 3'b111, 1'b0, 64'hF0, 64'h3C, 64'h30, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{2'b10, 3'b110, 1'b0, 64'hF0, 64'h0F, 64'hFF, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{2'b00, 3'b101, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{2'b10, 3'b000, 1'b0, 64'd3, 64'd4, 64'd7, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{2'b01, 3'b100, 1'b0, 64'd9, 64'd4, 64'd5, 1'b0, 1'b0, BR_EN};
        vecs[11] = '{2'b10, 3'b000, 1'b1, 64'd3, 64'd10, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 1'b0, 1'b0};

        // Reset then idle.
        rst_n = 1'b0;
        drive_req(1'b0, 2'b00, 3'b000, 1'b0, '0, '0);
        bus.respReady_in = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("reset ready", W'(bus.reqReady_out), W'(1'b1));
        check("reset respValid", W'(bus.respValid_out), W'(1'b0));
        check("reset aluOp", W'(bus.aluOp_out), W'(3'b111));
        check("reset operand1", bus.aluOperand1_out, '0);
        check("reset result", bus.result_out, '0);
        check("reset illegal", W'(bus.illegal_out), W'(1'b0));

        // Table-driven single requests, no stall.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive_req(1'b1, vecs[i].cls, vecs[i].f3, vecs[i].f7, vecs[i].a, vecs[i].b);
            #1;
            check($sformatf("vec%0d ready", i), W'(bus.reqReady_out), W'(1'b1));
            @(negedge clk);
            bus.reqValid_in = 1'b0;
            check($sformatf("vec%0d early valid", i), W'(bus.respValid_out), W'(1'b0));
            @(negedge clk);
            check($sformatf("vec%0d valid", i), W'(bus.respValid_out), W'(1'b1));
            check_resp($sformatf("vec%0d", i), vec_resp(vecs[i]));
        end
        @(negedge clk);

        // Back-to-back stream with response backpressure.
        bus.respReady_in = 1'b0;
        accepts = 0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c >= 3) begin
                check($sformatf("hold result c%0d", c), bus.result_out, vecs[0].exp_res);
                check($sformatf("hold aluOp c%0d", c), W'(bus.aluOp_out), W'(OP_SUB));
                check($sformatf("hold operand1 c%0d", c), bus.aluOperand1_out, vecs[1].a);
            end
            drive_req(1'b1, vecs[idx].cls, vecs[idx].f3, vecs[idx].f7, vecs[idx].a, vecs[idx].b);
            #1;
            if (bus.reqReady_out) begin
                accepts++;
                idx++;
            end
        end
        check("stall accepts", W'(accepts), W'(2));
        check("stall ready", W'(bus.reqReady_out), W'(1'b0));
        check("stall respValid", W'(bus.respValid_out), W'(1'b1));

        got = 0;
        first_cyc = -1;
        last_cyc = -1;
        for (int c = 0; c < 12 && got < 4; c++) begin
            @(negedge clk);
            bus.respReady_in = 1'b1;
            if (idx < 4) drive_req(1'b1, vecs[idx].cls, vecs[idx].f3, vecs[idx].f7, vecs[idx].a, vecs[idx].b);
            else         bus.reqValid_in = 1'b0;
            #1;
            if (bus.respValid_out) begin
                check_resp($sformatf("drain%0d", got), vec_resp(vecs[got]));
                if (first_cyc < 0) first_cyc = c;
                last_cyc = c;
                got++;
            end
            if (bus.reqValid_in && bus.reqReady_out) idx++;
        end
        check("drain count", W'(got), W'(4));
        check("drain one per cycle", W'(last_cyc - first_cyc), W'(3));
        @(negedge clk);
        bus.reqValid_in = 1'b0;

        // Randomized traffic against the scoreboard.
        prev_stall = 1'b0;
        prev_res = '0;
        for (int c = 0; c < 400; c++) begin
            logic [W-1:0] a, b;
            @(negedge clk);
            if (prev_stall) begin
                check("rand stall valid", W'(bus.respValid_out), W'(1'b1));
                check("rand stall result", bus.result_out, prev_res);
            end
            a = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : {$urandom, $urandom};
            b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
            drive_req($urandom_range(0, 3) != 0, 2'($urandom), 3'($urandom), 1'($urandom), a, b);
            bus.respReady_in = ($urandom_range(0, 2) != 0);
            #1;
            if (bus.respValid_out && bus.respReady_in) begin
                if (exp_q.size() == 0) begin
                    check("rand unexpected response", W'(bus.respValid_out), W'(1'b0));
                end else begin
                    e = exp_q.pop_front();
                    check_resp("rand", e);
                end
            end
            prev_stall = bus.respValid_out && !bus.respReady_in;
            prev_res = bus.result_out;
            if (bus.reqValid_in && bus.reqReady_out) begin
                exp_q.push_back(model(bus.aluClass_in, bus.funct3_in, bus.funct7b5_in, a, b));
            end
        end
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            bus.reqValid_in = 1'b0;
            bus.respReady_in = 1'b1;
            #1;
            if (bus.respValid_out) begin
                e = exp_q.pop_front();
                check_resp("rand drain", e);
            end
        end
        check("rand queue empty", W'(exp_q.size()), W'(0));

        // Reset with both stages full.
        @(negedge clk);
        bus.respReady_in = 1'b0;
        for (int c = 0; c < 2; c++) begin
            drive_req(1'b1, vecs[c].cls, vecs[c].f3, vecs[c].f7, vecs[c].a, vecs[c].b);
            @(negedge clk);
        end
        bus.reqValid_in = 1'b0;
        check("full respValid", W'(bus.respValid_out), W'(1'b1));
        check("full ready", W'(bus.reqReady_out), W'(1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset respValid", W'(bus.respValid_out), W'(1'b0));
        check("async reset ready", W'(bus.reqReady_out), W'(1'b1));
        check("async reset aluOp", W'(bus.aluOp_out), W'(OP_ADD));
        check("async reset result", bus.result_out, '0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.respReady_in = 1'b1;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.respValid_out) seen++;
        end
        check("no response after reset", W'(seen), W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequential front end for the combinational ALU. It accepts decoded execute-stage requests over a valid/ready handshake and translates the main-control ALU class plus funct fields into an `aluOperation_t`. It drives the ALU from a registered issue stage, then captures the result, zero flag and branch decision into a registered response stage with backpressure. It sits between decode and memory/writeback, in the initiator role toward the ALU.

## Interface
Parameters:
- `DATA_WIDTH_POW`, 6: operand width is `1 << DATA_WIDTH_POW`, called W below.

Ports:
- `clk_in`  in  1  clock; all state changes on the rising edge.
- `rstN_in`  in  1  reset, asynchronous assert, active-low.
- `reqValid_in`  in  1  request valid.
- `reqReady_out`  out  1  request accepted when this and `reqValid_in` are both high.
- `aluClass_in`  in  2  00 = load/store, 01 = branch, 10 = R-type, 11 = reserved.
- `funct3_in`  in  3  instruction funct3.
- `funct7b5_in`  in  1  instruction bit 30.
- `operand1_in`, `operand2_in`  in  W  source operands.
- `aluOp_out`  out  3  registered opcode to the ALU.
- `aluOperand1_out`, `aluOperand2_out`  out  W  registered operands to the ALU.
- `aluResult_in`  in  W  ALU result, combinational from `alu*_out`.
- `aluZero_in`  in  1  ALU zero flag.
- `respValid_out`  out  1  response valid.
- `respReady_in`  in  1  downstream accepts the response.
- `result_out`  out  W  captured result.
- `zeroFlag_out`  out  1  captured zero flag.
- `branchTaken_out`  out  1  branch decision.
- `illegal_out`  out  1  request decoded to an unsupported operation.

## Operation
- Opcode encodings: `OP_ADD` = 111, `OP_SUB` = 000, `OP_AND` = 001, `OP_OR` = 011.
- Decode happens on acceptance and is registered into S0:
  - Class 00 → `OP_ADD`.
  - Class 01 → `OP_SUB`.
  - Class 10 with funct3 000 → `OP_ADD` if funct7b5 = 0, `OP_SUB` if funct7b5 = 1.
  - Class 10 with funct3 111 → `OP_AND`; funct3 110 → `OP_OR`.
  - Any other combination → `OP_ADD` with the illegal bit set.
- Two pipeline stages:
  - S0 (issue): valid bit, opcode, operands, class, funct3, illegal bit.
  - S1 (response): valid bit, result, zero flag, branchTaken, illegal bit.
- Stage movement:
  - S1 loads from S0 when S0 is valid and (S1 is empty or `respReady_in` is high).
  - S1 clears when `respReady_in` is high and nothing loads into it.
- Ready: `reqReady_out` = !S0valid OR S0 advancing this cycle. This is full throughput, with no bubble under continuous valid/ready.
- S0 holds `aluOp_out` and the operands stable while stalled. The ALU inputs change only on S0 load.
- With S0 empty, the `alu*_out` signals hold their last values. There is no combinational path from `reqValid_in` to `alu*_out`.
- Branch resolution and illegal-branch flagging are covered under Configuration.

## Timing
- Reset (async, `rstN_in` low):
  - Both valid bits clear.
  - `respValid_out` = 0, `reqReady_out` = 1.
  - `aluOp_out` = `OP_ADD`; operands, `result_out`, `zeroFlag_out`, `branchTaken_out` and `illegal_out` all 0.
- Reset mid-operation drops any in-flight requests without producing a response.
- Latency: a request accepted at edge N gives `respValid_out` high after edge N+1, assuming no stall.
- Response outputs stay stable while `respValid_out` = 1 and `respReady_in` = 0.
- Simultaneous events:
  - S1 full with `respReady_in` = 1: S1 drains and reloads in the same cycle.
  - S1 full, `respReady_in` = 0 and S0 full: `reqReady_out` = 0.
- Widths: W-bit modulo arithmetic, performed in the ALU. The block does no arithmetic of its own.

## Configuration
- `ALU_ISSUE_BRANCH_EN` defined: branch resolution is compiled in.
  - Class 01 with funct3 000 (BEQ): taken = `aluZero_in`.
  - Class 01 with funct3 001 (BNE): taken = !`aluZero_in`.
  - Any other class-01 funct3 sets illegal and forces taken = 0.
  - Non-branch classes give taken = 0.
  - S0 stores class and funct3 for this purpose.
- `ALU_ISSUE_BRANCH_EN` undefined:
  - `branchTaken_out` is tied to 0.
  - Class-01 funct3 is not checked and never flags illegal.
  - Class and funct3 storage is removed from S0.

## Structure
- `aluOperation_t` and the opcode constants live in the shared `ControlSignals` package.
- Also in `ControlSignals`: the 2-bit ALU class enum `aluClass_t` (`CLASS_MEM`, `CLASS_BRANCH`, `CLASS_RTYPE`, `CLASS_RSVD`) and the funct3 constants `F3_ADDSUB`, `F3_AND`, `F3_OR`, `F3_BEQ`, `F3_BNE`.
- Sub-module `alu_op_decode`: combinational mapping of class/funct3/funct7b5 to opcode and illegal bit.
- The ALU itself is external, not instantiated. The test bench connects it.

## Test plan
- Reset then idle → `reqReady_out` = 1, `respValid_out` = 0, `aluOp_out` = 111.
- R-type funct3 000, funct7b5 = 1, operands 10 and 3 → 2 cycles later `result_out` = 7, `zeroFlag_out` = 0, `illegal_out` = 0.
- Branch BEQ, operands 5 and 5 (macro on) → `branchTaken_out` = 1 and `zeroFlag_out` = 1. Same request as BNE → taken = 0. Macro off → taken = 0.
- Stream of 4 back-to-back requests with `respReady_in` = 0 → `reqReady_out` drops after 2 accepts and the outputs hold. Releasing `respReady_in` drains 4 responses in order, one per cycle.
- Class 10, funct3 010 → `illegal_out` = 1 and the result equals the ADD of the operands. Class 11 → `illegal_out` = 1.
- Assert `rstN_in` mid-stream with S0 and S1 full → immediate `respValid_out` = 0 with no clock required, and no response after release.
